// File: rtl/fpga_nano_pkg.sv
// Shared types and defaults for the FPGA-to-Nano pixel link.
package fpga_nano_pkg;

  localparam int PIXEL_W   = 12;
  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    PRESENT,
    FINISH
  } streamer_state_t;

endpackage

// File: rtl/frame_pixel_streamer_if.sv
// Valid/ready pixel stream from the frame streamer to the UART pixel sender.
interface frame_pixel_streamer_if;
  import fpga_nano_pkg::*;

  pixel_t pixel;
  logic   pixel_valid;
  logic   pixel_ready;
  logic   frame_first;

  modport master (output pixel, output pixel_valid, output frame_first, input pixel_ready);
  modport slave  (input pixel, input pixel_valid, input frame_first, output pixel_ready);

endinterface

// File: rtl/frame_pixel_streamer_raster_counter.sv
// Raster walker over a decimated frame: tracks x, y and the row base address with adds only.
module raster_counter
  import fpga_nano_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int DECIM  = 1,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0]     X_STEP   = XW'(DECIM);
  localparam logic [XW-1:0]     X_LAST   = XW'(IMG_W - DECIM);
  localparam logic [YW-1:0]     Y_STEP   = YW'(DECIM);
  localparam logic [YW-1:0]     Y_LAST   = YW'(IMG_H - DECIM);
  localparam logic [ADDR_W-1:0] A_STEP   = ADDR_W'(DECIM);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W * DECIM);

  logic [XW-1:0]     x_reg, x_next;
  logic [YW-1:0]     y_reg, y_next;
  logic [ADDR_W-1:0] row_base_reg, row_base_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;

  // addr is kept as its own register so the RAM port sees the new address
  // in the very cycle after a step, and holds it otherwise.
  always_comb begin
    x_next        = x_reg;
    y_next        = y_reg;
    row_base_next = row_base_reg;
    addr_next     = addr_reg;
    if (clear) begin
      x_next        = '0;
      y_next        = '0;
      row_base_next = '0;
      addr_next     = '0;
    end else if (step) begin
      if (x_reg == X_LAST) begin
        x_next        = '0;
        y_next        = y_reg + Y_STEP;
        row_base_next = row_base_reg + ROW_STEP;
        addr_next     = row_base_reg + ROW_STEP;
      end else begin
        x_next    = x_reg + X_STEP;
        addr_next = addr_reg + A_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg        <= '0;
      y_reg        <= '0;
      row_base_reg <= '0;
      addr_reg     <= '0;
    end else begin
      x_reg        <= x_next;
      y_reg        <= y_next;
      row_base_reg <= row_base_next;
      addr_reg     <= addr_next;
    end
  end

  assign addr = addr_reg;
  assign last = (x_reg == X_LAST) && (y_reg == Y_LAST);

endmodule

// File: rtl/frame_pixel_streamer.sv
// Walks one frame-buffer frame in raster order and hands pixels to the UART sender.
module frame_pixel_streamer
  import fpga_nano_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int DECIM  = 1,
  parameter int ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     rd_addr,
  input  pixel_t                rd_data,
  frame_pixel_streamer_if.master pix
);

  streamer_state_t state_reg, state_next;
  logic   busy_reg, busy_next;
  logic   done_reg, done_next;
  pixel_t pixel_reg, pixel_next;
  logic   valid_reg, valid_next;
  logic   first_reg, first_next;
  logic   clear, step, last;

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .DECIM (DECIM),
    .ADDR_W(ADDR_W)
  ) u_raster (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .step (step),
    .addr (rd_addr),
    .last (last)
  );

  always_comb begin
    state_next = state_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    pixel_next = pixel_reg;
    valid_next = valid_reg;
    first_next = first_reg;
    clear      = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          busy_next  = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: state_next = WAIT_RD;
      WAIT_RD: begin
        pixel_next = rd_data;
        valid_next = 1'b1;
        first_next = (rd_addr == '0);
        state_next = PRESENT;
      end
      PRESENT: begin
        if (pix.pixel_ready) begin
          valid_next = 1'b0;
          first_next = 1'b0;
          // Counters stay on the last pixel so rd_addr never runs past the frame.
          if (last) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = FINISH;
          end else begin
            step       = 1'b1;
            state_next = FETCH;
          end
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      pixel_reg <= '0;
      valid_reg <= 1'b0;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      pixel_reg <= pixel_next;
      valid_reg <= valid_next;
      first_reg <= first_next;
    end
  end

  assign busy            = busy_reg;
  assign done            = done_reg;
  assign pix.pixel       = pixel_reg;
  assign pix.pixel_valid = valid_reg;
  assign pix.frame_first = first_reg;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Directed plus randomized-backpressure bench for frame_pixel_streamer (4x3/1 and 4x4/2 builds).
module tb_frame_pixel_streamer;
  import fpga_nano_pkg::*;

  localparam int AW = 4, AH = 3, AD = 1;
  localparam int BW = 4, BH = 4, BD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, busy_b, done_b;
  logic [3:0] rd_addr_a;
  logic [4:0] rd_addr_b;
  pixel_t rd_data_a, rd_data_b;
  int n_cmp = 0;
  int n_err = 0;

  frame_pixel_streamer_if pa ();
  frame_pixel_streamer_if pb ();

  frame_pixel_streamer #(.IMG_W(AW), .IMG_H(AH), .DECIM(AD), .ADDR_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .pix(pa)
  );

  frame_pixel_streamer #(.IMG_W(BW), .IMG_H(BH), .DECIM(BD), .ADDR_W(5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .pix(pb)
  );

  always #5 clk = ~clk;

  // Frame-buffer RAMs: mem[a] = 12'h100 + a, one-cycle registered read.
  always_ff @(posedge clk) begin
    rd_data_a <= 12'h100 + 12'(rd_addr_a);
    rd_data_b <= 12'h100 + 12'(rd_addr_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_valid"}, pa.pixel_valid, 0);
    check({tag, "_first"}, pa.frame_first, 0);
    check({tag, "_pixel"}, pa.pixel, 0);
    check({tag, "_rd_addr"}, rd_addr_a, 0);
  endtask

  // mode 0: ready high, 1: ready low for 20 stalled cycles then high, 2: random ready.
  task automatic stream_frame(input int mode, input int restart_at, input int rst_at,
                              input bit finish_start);
    pixel_t exp_q[$];
    int got = 0;
    int total;
    int stall = 0;
    int last_hs_c = -1;
    bit hs, hs_prev = 0, hs_last_prev = 0, pend = 0, done_seen = 0, aborted = 0;
    for (int yy = 0; yy < AH; yy += AD)
      for (int xx = 0; xx < AW; xx += AD)
        exp_q.push_back(12'h100 + 12'(yy * AW + xx));
    total = exp_q.size();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("busy_on_start", busy_a, 1);
    check("valid_in_fetch", pa.pixel_valid, 0);
    tick();
    check("valid_in_wait", pa.pixel_valid, 0);
    tick();
    check("first_valid_latency", pa.pixel_valid, 1);
    for (int c = 0; c < 3000 && !done_seen && !aborted; c++) begin
      case (mode)
        0:       pa.pixel_ready = 1'b1;
        1:       pa.pixel_ready = (stall >= 20);
        default: pa.pixel_ready = 1'($urandom_range(0, 1));
      endcase
      check("done", done_a, hs_last_prev);
      check("busy", busy_a, !hs_last_prev);
      if (pend) begin
        check("hold_valid", pa.pixel_valid, 1);
        check("hold_pixel", pa.pixel, exp_q.size() > 0 ? exp_q[0] : 12'hFFF);
      end
      if (hs_prev) check("valid_drop", pa.pixel_valid, 0);
      if (hs_last_prev) begin
        done_seen = 1'b1;
      end else begin
        hs = pa.pixel_valid && pa.pixel_ready;
        if (pa.pixel_valid && !hs) stall++;
        if (restart_at >= 0 && pa.pixel_valid && got == restart_at) start_a = 1'b1;
        if (hs) begin
          check("pixel", pa.pixel, exp_q.size() > 0 ? exp_q.pop_front() : 12'hFFF);
          check("frame_first", pa.frame_first, got == 0);
          if (mode == 0 && last_hs_c >= 0) check("throughput", c - last_hs_c, 3);
          last_hs_c = c;
          got++;
          $display("pixel #%0d = %03h first=%0b", got, pa.pixel, pa.frame_first);
        end
        hs_last_prev = hs && (got == total);
        pend = pa.pixel_valid && !hs;
        hs_prev = hs;
        if (rst_at > 0 && hs && got == rst_at) begin
          rst = 1'b1;
          aborted = 1'b1;
        end
        tick();
        start_a = 1'b0;
      end
    end
    if (aborted) begin
      rst = 1'b0;
      check_a_zero("after_mid_rst");
      check("count_at_rst", got, rst_at);
      for (int k = 0; k < 4; k++) begin
        tick();
        check("no_done_after_rst", done_a, 0);
        check("idle_after_rst", busy_a, 0);
      end
    end else begin
      check("pixel_count", got, total);
      if (finish_start) begin
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("finish_start_busy", busy_a, 0);
        check("finish_start_done", done_a, 0);
      end else begin
        for (int k = 0; k < 5; k++) begin
          tick();
          check("single_done", done_a, 0);
          check("idle_busy", busy_a, 0);
        end
      end
    end
  endtask

  initial begin
    int exp_b[$];
    int got_b;
    int done_cnt_b;
    pa.pixel_ready = 1'b0;
    pb.pixel_ready = 1'b0;
    repeat (3) tick();
    check_a_zero("reset");
    check("reset_b_addr", rd_addr_b, 0);
    check("reset_b_valid", pb.pixel_valid, 0);
    rst = 1'b0;
    tick();

    stream_frame(0, -1, -1, 1'b0);   // free-running frame
    stream_frame(1, -1, -1, 1'b0);   // long stall on pixel 100
    stream_frame(2, -1, -1, 1'b1);   // random backpressure, start in FINISH ignored
    stream_frame(2, -1, -1, 1'b1);   // accepted in first IDLE cycle
    stream_frame(0, 4, -1, 1'b0);    // start re-pulsed while 104 presented
    stream_frame(2, -1, 6, 1'b0);    // reset after the 6th pixel
    stream_frame(0, -1, -1, 1'b0);   // clean restart after reset

    // Decimated build: every 2nd column and row of a 4x4 frame.
    for (int yy = 0; yy < BH; yy += BD)
      for (int xx = 0; xx < BW; xx += BD)
        exp_b.push_back(yy * BW + xx);
    got_b = 0;
    done_cnt_b = 0;
    pb.pixel_ready = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 0; c < 200 && done_cnt_b == 0; c++) begin
      check("b_rd_addr_range", rd_addr_b <= 5'd15, 1);
      if (done_b) begin
        done_cnt_b++;
        check("b_done_after_last", got_b, 4);
      end else if (pb.pixel_valid) begin
        check("b_addr", 32'(pb.pixel) - 32'h100, exp_b.size() > 0 ? exp_b.pop_front() : 99);
        got_b++;
        $display("decim pixel #%0d = %03h", got_b, pb.pixel);
      end
      if (done_cnt_b == 0) tick();
    end
    check("b_done_count", done_cnt_b, 1);
    check("b_pixel_count", got_b, 4);
    tick();
    check("b_idle", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
